irrigation_scheduler: RTL and testbench

Sequences the shared water supply between the dripper and sprinkler valves. Takes raw open requests from the dripper and sprinkler decision logic and debounces them. Grants at most one valve at a time, primes the pump before opening a valve, and enforces minimum/maximum run times and a settle gap. Forces everything closed on critical water level or supply-sensor error. Sits between the valve decision logic and the physical valve/pump drivers inside the irrigation controller.

---
 rtl/irrigation_scheduler_if.sv | 31 +++
 rtl/irrigation_scheduler.sv | 141 ++++++++++++++
 tb/tb_irrigation_scheduler.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/irrigation_scheduler_if.sv
// rtl/irrigation_scheduler_if.sv - request/fault inputs and valve/pump outputs of the irrigation scheduler
//
// master : valve decision logic side (drives requests and faults, observes valve/pump state)
// slave  : irrigation_scheduler side
//   dripper_request, sprinkler_request   raw open requests
//   critical_water_level, sensor_error   supply faults
//   dripper_valvule, sprinkler_valvule   valve open commands
//   pump_enable                          supply pump on
//   alarm                                lockout indicator
//   state_code[2:0]                      current scheduler state
interface irrigation_scheduler_if;
    logic       dripper_request;
    logic       sprinkler_request;
    logic       critical_water_level;
    logic       sensor_error;
    logic       dripper_valvule;
    logic       sprinkler_valvule;
    logic       pump_enable;
    logic       alarm;
    logic [2:0] state_code;

    modport master (
        output dripper_request, sprinkler_request, critical_water_level, sensor_error,
        input  dripper_valvule, sprinkler_valvule, pump_enable, alarm, state_code
    );

    modport slave (
        input  dripper_request, sprinkler_request, critical_water_level, sensor_error,
        output dripper_valvule, sprinkler_valvule, pump_enable, alarm, state_code
    );
endinterface

// File: rtl/irrigation_scheduler.sv
// rtl/irrigation_scheduler.sv - debounced, single-grant pump/valve sequencer with fault lockout
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    irrigation_scheduler_if.slave: raw requests and faults in;
//          valve, pump, alarm and state_code out (Moore decodes of the state)
module irrigation_scheduler #(
    parameter int CNT_W           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PRIME_CYCLES    = 8,
    parameter int MIN_RUN_CYCLES  = 16,
    parameter int MAX_RUN_CYCLES  = 200,
    parameter int SETTLE_CYCLES   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    irrigation_scheduler_if.slave   bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PRIME    = 3'd1;
    localparam logic [2:0] S_DRIP     = 3'd2;
    localparam logic [2:0] S_SPRINKLE = 3'd3;
    localparam logic [2:0] S_SETTLE   = 3'd4;
    localparam logic [2:0] S_LOCKOUT  = 3'd5;

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRIME_LAST  = CNT_W'(PRIME_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] drip_cnt, spr_cnt;
    logic             drip_filt, spr_filt;
    // 1 = sprinkler, 0 = dripper, for both the active grant and the last one served
    logic             grant_spr, grant_nxt;
    logic             last_spr;
    logic             fault;
    logic             granted_filt;

    assign fault        = bus.critical_water_level | bus.sensor_error;
    assign granted_filt = grant_spr ? spr_filt : drip_filt;

    // Debounce: filtered value follows raw only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drip_filt <= 1'b0;
            drip_cnt  <= '0;
        end else if (bus.dripper_request == drip_filt) begin
            drip_cnt  <= '0;
        end else if (drip_cnt == DEB_LAST) begin
            drip_filt <= ~drip_filt;
            drip_cnt  <= '0;
        end else begin
            drip_cnt  <= drip_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spr_filt <= 1'b0;
            spr_cnt  <= '0;
        end else if (bus.sprinkler_request == spr_filt) begin
            spr_cnt  <= '0;
        end else if (spr_cnt == DEB_LAST) begin
            spr_filt <= ~spr_filt;
            spr_cnt  <= '0;
        end else begin
            spr_cnt  <= spr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_spr;
        if (fault) begin
            state_nxt = S_LOCKOUT;
        end else begin
            case (state)
                S_IDLE: begin
                    if (drip_filt && spr_filt) begin
                        grant_nxt = ~last_spr;
                        state_nxt = S_PRIME;
                    end else if (drip_filt) begin
                        grant_nxt = 1'b0;
                        state_nxt = S_PRIME;
                    end else if (spr_filt) begin
                        grant_nxt = 1'b1;
                        state_nxt = S_PRIME;
                    end
                end
                S_PRIME: begin
                    // A withdrawn request aborts priming before any valve opens.
                    if (!granted_filt)
                        state_nxt = S_SETTLE;
                    else if (timer == PRIME_LAST)
                        state_nxt = grant_spr ? S_SPRINKLE : S_DRIP;
                end
                S_DRIP, S_SPRINKLE: begin
                    if ((!granted_filt && timer >= MIN_LAST) || timer == MAX_LAST)
                        state_nxt = S_SETTLE;
                end
                S_SETTLE: begin
                    if (timer == SETTLE_LAST)
                        state_nxt = S_IDLE;
                end
                S_LOCKOUT: state_nxt = S_SETTLE;   // reached only with fault already low
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            grant_spr <= 1'b0;
            last_spr  <= 1'b1;
        end else begin
            state     <= state_nxt;
            grant_spr <= grant_nxt;
            if (state_nxt != state)
                timer <= '0;
            else if (timer != {CNT_W{1'b1}})
                timer <= timer + 1'b1;
            // Fairness only advances on a completed run, not on a fault abort.
            if ((state == S_DRIP || state == S_SPRINKLE) && state_nxt == S_SETTLE)
                last_spr <= grant_spr;
        end
    end

    assign bus.pump_enable       = (state == S_PRIME) || (state == S_DRIP) || (state == S_SPRINKLE);
    assign bus.dripper_valvule   = (state == S_DRIP);
    assign bus.sprinkler_valvule = (state == S_SPRINKLE);
    assign bus.alarm             = (state == S_LOCKOUT);
    assign bus.state_code        = state;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// tb/tb_irrigation_scheduler.sv - directed self-checking bench for irrigation_scheduler
module tb_irrigation_scheduler;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    irrigation_scheduler_if bus();

    irrigation_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] seg_state [0:15];
    int         seg_len   [0:15];
    int         nseg;
    logic       both_seen;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.dripper_request      = 1'b0;
        bus.sprinkler_request    = 1'b0;
        bus.critical_water_level = 1'b0;
        bus.sensor_error         = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Records run-length segments of state_code over n cycles.
    task automatic run_log(input int n);
        for (int k = 0; k < 16; k++) begin
            seg_state[k] = 3'd7;
            seg_len[k]   = 0;
        end
        nseg      = 0;
        both_seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.dripper_valvule && bus.sprinkler_valvule)
                both_seen = 1'b1;
            if (nseg > 0 && seg_state[nseg-1] == bus.state_code) begin
                seg_len[nseg-1] = seg_len[nseg-1] + 1;
            end else if (nseg < 16) begin
                seg_state[nseg] = bus.state_code;
                seg_len[nseg]   = 1;
                nseg++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.dripper_request      = 1'b1;
        bus.sprinkler_request    = 1'b1;
        bus.critical_water_level = 1'b0;
        bus.sensor_error         = 1'b0;
        tick();
        tick();
        compared++;
        if ({bus.dripper_valvule, bus.sprinkler_valvule, bus.pump_enable, bus.alarm, bus.state_code} !== 7'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got dv=%b sv=%b pump=%b alarm=%b state=%0d, want all 0",
                     bus.dripper_valvule, bus.sprinkler_valvule, bus.pump_enable, bus.alarm, bus.state_code);
        end
    endtask

    task automatic test_basic_grant();
        do_reset();
        bus.dripper_request = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        compared++;
        if (bus.state_code !== 3'd0 || bus.pump_enable !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_edge4: got state=%0d pump=%b, want state=0 pump=0", bus.state_code, bus.pump_enable);
        end
        tick();
        compared++;
        if (bus.state_code !== 3'd1 || bus.pump_enable !== 1'b1 || bus.dripper_valvule !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_prime: got state=%0d pump=%b dv=%b, want state=1 pump=1 dv=0",
                     bus.state_code, bus.pump_enable, bus.dripper_valvule);
        end
        for (int i = 0; i < 7; i++) tick();
        compared++;
        if (bus.state_code !== 3'd1) begin
            mismatched++;
            $display("FAIL basic_edge12: got state=%0d, want 1", bus.state_code);
        end
        tick();
        compared++;
        if (bus.state_code !== 3'd2 || bus.dripper_valvule !== 1'b1 || bus.pump_enable !== 1'b1 ||
            bus.sprinkler_valvule !== 1'b0 || bus.alarm !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_drip: got state=%0d dv=%b pump=%b sv=%b alarm=%b, want 2 1 1 0 0",
                     bus.state_code, bus.dripper_valvule, bus.pump_enable, bus.sprinkler_valvule, bus.alarm);
        end
    endtask

    task automatic test_glitch_reject();
        do_reset();
        bus.dripper_request = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus.dripper_request = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            compared++;
            if (bus.state_code !== 3'd0 || bus.pump_enable !== 1'b0 || bus.dripper_valvule !== 1'b0) begin
                mismatched++;
                $display("FAIL glitch_cycle%0d: got state=%0d pump=%b dv=%b, want 0 0 0",
                         i, bus.state_code, bus.pump_enable, bus.dripper_valvule);
            end
        end
    endtask

    task automatic test_min_run();
        logic [2:0] es [3];
        int         el [3];
        es = '{3'd2, 3'd4, 3'd0};
        el = '{14, 8, 8};
        do_reset();
        bus.dripper_request = 1'b1;
        for (int i = 0; i < 14; i++) tick();   // two DRIP cycles observed
        bus.dripper_request = 1'b0;
        run_log(30);
        for (int k = 0; k < 3; k++) begin
            compared++;
            if (seg_state[k] !== es[k] || seg_len[k] !== el[k]) begin
                mismatched++;
                $display("FAIL minrun_seg%0d: got state=%0d len=%0d, want state=%0d len=%0d",
                         k, seg_state[k], seg_len[k], es[k], el[k]);
            end
        end
    endtask

    task automatic test_alternation();
        logic [2:0] es [11];
        int         el [11];
        es = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2};
        el = '{4, 8, 200, 8, 1, 8, 200, 8, 1, 8, 4};
        do_reset();
        bus.dripper_request   = 1'b1;
        bus.sprinkler_request = 1'b1;
        run_log(450);
        for (int k = 0; k < 11; k++) begin
            compared++;
            if (seg_state[k] !== es[k] || seg_len[k] !== el[k]) begin
                mismatched++;
                $display("FAIL alt_seg%0d: got state=%0d len=%0d, want state=%0d len=%0d",
                         k, seg_state[k], seg_len[k], es[k], el[k]);
            end
        end
        compared++;
        if (both_seen !== 1'b0) begin
            mismatched++;
            $display("FAIL alt_exclusive: got both valves open=%b, want 0", both_seen);
        end
    endtask

    task automatic test_fault_lockout();
        logic [2:0] es [4];
        int         el [4];
        es = '{3'd4, 3'd0, 3'd1, 3'd3};
        el = '{8, 1, 8, 1};
        do_reset();
        bus.sprinkler_request = 1'b1;
        run_log(18);
        compared++;
        if (bus.state_code !== 3'd3 || seg_len[2] !== 6) begin
            mismatched++;
            $display("FAIL fault_presprinkle: got state=%0d sprinkle_len=%0d, want 3 6", bus.state_code, seg_len[2]);
        end
        bus.critical_water_level = 1'b1;
        tick();
        bus.critical_water_level = 1'b0;
        compared++;
        if (bus.state_code !== 3'd5 || bus.alarm !== 1'b1 || bus.pump_enable !== 1'b0 ||
            bus.sprinkler_valvule !== 1'b0 || bus.dripper_valvule !== 1'b0) begin
            mismatched++;
            $display("FAIL fault_lockout: got state=%0d alarm=%b pump=%b sv=%b dv=%b, want 5 1 0 0 0",
                     bus.state_code, bus.alarm, bus.pump_enable, bus.sprinkler_valvule, bus.dripper_valvule);
        end
        run_log(18);
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (seg_state[k] !== es[k] || seg_len[k] !== el[k]) begin
                mismatched++;
                $display("FAIL fault_seg%0d: got state=%0d len=%0d, want state=%0d len=%0d",
                         k, seg_state[k], seg_len[k], es[k], el[k]);
            end
        end
        bus.sensor_error = 1'b1;
        run_log(3);
        compared++;
        if (seg_state[0] !== 3'd5 || seg_len[0] !== 3 || bus.alarm !== 1'b1) begin
            mismatched++;
            $display("FAIL sensor_lockout: got state=%0d len=%0d alarm=%b, want 5 3 1", seg_state[0], seg_len[0], bus.alarm);
        end
        bus.sensor_error = 1'b0;
        tick();
        compared++;
        if (bus.state_code !== 3'd4 || bus.alarm !== 1'b0) begin
            mismatched++;
            $display("FAIL sensor_exit: got state=%0d alarm=%b, want 4 0", bus.state_code, bus.alarm);
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] es [3];
        int         el [3];
        es = '{3'd0, 3'd1, 3'd2};
        el = '{4, 8, 2};
        do_reset();
        bus.dripper_request = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        compared++;
        if (bus.state_code !== 3'd2 || bus.dripper_valvule !== 1'b1) begin
            mismatched++;
            $display("FAIL areset_pre: got state=%0d dv=%b, want 2 1", bus.state_code, bus.dripper_valvule);
        end
        #2;
        reset = 1'b1;
        #1;
        compared++;
        if (bus.dripper_valvule !== 1'b0 || bus.pump_enable !== 1'b0 || bus.state_code !== 3'd0) begin
            mismatched++;
            $display("FAIL areset_immediate: got dv=%b pump=%b state=%0d, want 0 0 0",
                     bus.dripper_valvule, bus.pump_enable, bus.state_code);
        end
        tick();
        reset = 1'b0;
        run_log(14);
        for (int k = 0; k < 3; k++) begin
            compared++;
            if (seg_state[k] !== es[k] || seg_len[k] !== el[k]) begin
                mismatched++;
                $display("FAIL areset_seg%0d: got state=%0d len=%0d, want state=%0d len=%0d",
                         k, seg_state[k], seg_len[k], es[k], el[k]);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        bus.dripper_request      = 1'b0;
        bus.sprinkler_request    = 1'b0;
        bus.critical_water_level = 1'b0;
        bus.sensor_error         = 1'b0;
        test_reset();
        test_basic_grant();
        test_glitch_reject();
        test_min_run();
        test_alternation();
        test_fault_lockout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
